// File: rtl/neopixel_pkg.sv
// Shared types and constants for the NeoPixel frame source and colour wheel.
package neopixel_pkg;

  localparam int GRB_W = 24;
  localparam logic [7:0] WHEEL_SEG  = 8'd85;
  localparam logic [7:0] WHEEL_SEG2 = 8'd170;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    WAIT_TICK,
    STREAM,
    WAIT_LATCH
  } state_t;

  // (c * (b + 1)) >> 8: b=255 is identity, b=0 blanks the channel.
  function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = {8'd0, c} * ({8'd0, b} + 16'd1);
    return prod[15:8];
  endfunction

endpackage

// File: rtl/neopixel_frame_source_if.sv
// Valid/ready pixel stream from an animation source to the WS2812 serializer.
interface neopixel_frame_source_if;
  import neopixel_pkg::*;

  logic             pix_valid;
  logic             pix_ready;
  logic [GRB_W-1:0] pix_data;
  logic             pix_first;
  logic             pix_last;

  modport master (output pix_valid, pix_data, pix_first, pix_last, input pix_ready);
  modport slave  (input pix_valid, pix_data, pix_first, pix_last, output pix_ready);
endinterface

// File: rtl/neopixel_color_wheel.sv
// Combinational rainbow wheel: three 85-step ramps mapping hue[7:0] to GRB.
module neopixel_color_wheel
  import neopixel_pkg::*;
(
  input  logic [7:0] hue_i,
  output pixel_t     pix_o
);

  logic [7:0] k;
  logic [7:0] up;
  logic [7:0] down;

  always_comb begin
    if (hue_i < WHEEL_SEG) begin
      k = hue_i;
    end else if (hue_i < WHEEL_SEG2) begin
      k = hue_i - WHEEL_SEG;
    end else begin
      k = hue_i - WHEEL_SEG2;
    end
    up   = (k << 1) + k;
    down = 8'd255 - up;
  end

  always_comb begin
    pix_o = '0;
    if (hue_i < WHEEL_SEG) begin
      pix_o.r = down;
      pix_o.g = up;
    end else if (hue_i < WHEEL_SEG2) begin
      pix_o.g = down;
      pix_o.b = up;
    end else begin
      pix_o.r = up;
      pix_o.b = down;
    end
  end

endmodule

// File: rtl/neopixel_frame_source.sv
// Paces rainbow frames from a cycle divider and streams NUM_LEDS GRB words per frame.
// Optional NEOPIXEL_BRIGHTNESS_EN adds a brightness[7:0] input scaling every channel.
module neopixel_frame_source
  import neopixel_pkg::*;
#(
  parameter int NUM_LEDS    = 8,
  parameter int FRAME_DIV   = 416667,
  parameter int HUE_STEP    = 1,
  parameter int HUE_SPACING = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic latch_done,
`ifdef NEOPIXEL_BRIGHTNESS_EN
  input  logic [7:0] brightness,
`endif
  neopixel_frame_source_if.master pix
);

  localparam int DIV_W = $clog2(FRAME_DIV);
  localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_LEDS - 1);
  localparam logic [7:0]       STEP8    = 8'(HUE_STEP);
  localparam logic [7:0]       SPACING8 = 8'(HUE_SPACING);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             tick_pending_q, tick_pending_d;
  logic [7:0]       base_hue_q, base_hue_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  pixel_t           data_q, data_d;

  logic             tick;
  logic             start;
  logic [IDX_W-1:0] load_idx;
  logic [7:0]       load_hue;
  pixel_t           wheel_pix;
  pixel_t           load_pix;

  assign tick  = (div_cnt_q == DIV_LAST);
  assign start = (state_q == WAIT_TICK) && tick_pending_q && run;

  // Hue of the word about to be registered, so each handshake reloads without a stall.
  assign load_idx = start ? '0 : idx_q + 1'b1;
  assign load_hue = base_hue_q + 8'(load_idx) * SPACING8;

  neopixel_color_wheel u_wheel (
    .hue_i (load_hue),
    .pix_o (wheel_pix)
  );

`ifdef NEOPIXEL_BRIGHTNESS_EN
  assign load_pix.g = scale_chan(wheel_pix.g, brightness);
  assign load_pix.r = scale_chan(wheel_pix.r, brightness);
  assign load_pix.b = scale_chan(wheel_pix.b, brightness);
`else
  assign load_pix = wheel_pix;
`endif

  always_comb begin
    state_d        = state_q;
    base_hue_d     = base_hue_q;
    idx_d          = idx_q;
    valid_d        = valid_q;
    first_d        = first_q;
    last_d         = last_q;
    data_d         = data_q;
    div_cnt_d      = tick ? '0 : div_cnt_q + 1'b1;
    tick_pending_d = tick ? 1'b1 : (start ? 1'b0 : tick_pending_q);

    unique case (state_q)
      WAIT_TICK: begin
        if (start) begin
          state_d = STREAM;
          valid_d = 1'b1;
          idx_d   = load_idx;
          first_d = 1'b1;
          last_d  = (load_idx == IDX_LAST);
          data_d  = load_pix;
        end
      end
      STREAM: begin
        if (valid_q && pix.pix_ready) begin
          if (idx_q == IDX_LAST) begin
            state_d = WAIT_LATCH;
            valid_d = 1'b0;
            first_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            idx_d   = load_idx;
            first_d = 1'b0;
            last_d  = (load_idx == IDX_LAST);
            data_d  = load_pix;
          end
        end
      end
      WAIT_LATCH: begin
        if (latch_done) begin
          base_hue_d = base_hue_q + STEP8;
          state_d    = WAIT_TICK;
        end
      end
      default: state_d = WAIT_TICK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= WAIT_TICK;
      div_cnt_q      <= '0;
      tick_pending_q <= 1'b0;
      base_hue_q     <= '0;
      idx_q          <= '0;
      valid_q        <= 1'b0;
      first_q        <= 1'b0;
      last_q         <= 1'b0;
      data_q         <= '0;
    end else begin
      state_q        <= state_d;
      div_cnt_q      <= div_cnt_d;
      tick_pending_q <= tick_pending_d;
      base_hue_q     <= base_hue_d;
      idx_q          <= idx_d;
      valid_q        <= valid_d;
      first_q        <= first_d;
      last_q         <= last_d;
      data_q         <= data_d;
    end
  end

  assign pix.pix_valid = valid_q;
  assign pix.pix_data  = data_q;
  assign pix.pix_first = first_q;
  assign pix.pix_last  = last_q;

endmodule
